// File: rtl/fa_serial.sv
// Bit-serial full adder: one full-adder cell plus carry flop, LSB first.
// Optional overflow output enabled by FA_SERIAL_OVERFLOW_EN.
module fa_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef FA_SERIAL_OVERFLOW_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] sa, sb, work;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_next, last, accept;

  // single full-adder cell on the current LSBs
  always_comb begin
    s_bit  = sa[0] ^ sb[0] ^ carry;
    c_next = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    last   = (cnt == CW'(WIDTH - 1));
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state, handshake outputs and start acceptance
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // operand shifting, carry, bit count and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef FA_SERIAL_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      carry <= c;
      work  <= '0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      carry <= c_next;
      work  <= {s_bit, work[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= {s_bit, work[WIDTH-1:1]};
        cout <= c_next;
`ifdef FA_SERIAL_OVERFLOW_EN
        ovf  <= carry ^ c_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fa_serial.sv
// Scoreboard bench for fa_serial: directed cases plus random ops
// against an arithmetic reference model.
module tb_fa_serial;

  localparam int W = 8;
  localparam time P = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] da = '0, db = '0;
  logic         dc = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef FA_SERIAL_OVERFLOW_EN
  logic         ovf;
`endif

  fa_serial #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(da),
    .b(db),
    .c(dc),
    .busy(busy),
    .done(done),
    .sum(sum),
`ifdef FA_SERIAL_OVERFLOW_EN
    .cout(cout),
    .ovf(ovf)
`else
    .cout(cout)
`endif
  );

  always #(P/2) clk = ~clk;

  typedef struct {
    logic [W:0] r;
    logic       v;
    time        t;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         ndone = 0;
  logic [W:0] held = '0;
  logic       held_v = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                 logic ci, time t0);
    exp_t e;
    int unsigned tot;
    tot = int'(x) + int'(y) + int'(ci);
    e.r = (W+1)'(tot);
    e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
    e.t = t0;
    return e;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(logic [W-1:0] x, logic [W-1:0] y,
                       logic ci, bit push);
    wait_idle();
    start = 1'b1;
    da = x;
    db = y;
    dc = ci;
    if (push) q.push_back(model(x, y, ci, $time));
    @(negedge clk);
    start = 1'b0;
    da = W'($urandom());
    db = W'($urandom());
    dc = 1'b1;
  endtask

  task automatic wait_done_drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int bcnt;
    int d0;
    bit dprev;
    time t0;
    exp_t e;

    fork
      begin
        bcnt = 0;
        dprev = 1'b0;
        forever begin
          @(negedge clk);
          #1;
          if (rst) begin
            bcnt = 0;
            dprev = 1'b0;
            held = '0;
            held_v = 1'b0;
          end else begin
            if (busy) begin
              bcnt++;
            end else if (bcnt != 0) begin
              chk("busy_width", bcnt, W);
              bcnt = 0;
            end
            if (done) begin
              ndone++;
              chk("done_width", dprev, 0);
              if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
              end else begin
                e = q.pop_front();
                chk("result", {cout, sum}, e.r);
                chk("latency", ($time - 1) - e.t, (W+1)*P);
`ifdef FA_SERIAL_OVERFLOW_EN
                chk("ovf", ovf, e.v);
                held_v = e.v;
`endif
                held = e.r;
              end
            end else begin
              chk("hold", {cout, sum}, held);
`ifdef FA_SERIAL_OVERFLOW_EN
              chk("hold_ovf", ovf, held_v);
`endif
            end
            dprev = done;
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    issue(8'h12, 8'h34, 1'b0, 1'b1);
    wait_done_drain();
    issue(8'h55, 8'h66, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    d0 = ndone;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    repeat (W + 3) @(negedge clk);
    chk("abort_no_done", ndone - d0, 0);

    issue(8'h00, 8'h00, 1'b0, 1'b1);
    issue(8'hFF, 8'h01, 1'b0, 1'b1);
    issue(8'h7F, 8'h01, 1'b0, 1'b1);
    issue(8'hA5, 8'h5A, 1'b1, 1'b1);
    wait_done_drain();

    d0 = ndone;
    issue(8'h03, 8'h04, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    da = 8'hFF;
    db = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done_drain();
    repeat (3) @(negedge clk);
    chk("ignore_one_done", ndone - d0, 1);
    chk("ignore_sum", sum, 8'h07);

    wait_idle();
    t0 = $time;
    start = 1'b1;
    da = 8'h01;
    db = 8'h02;
    dc = 1'b0;
    q.push_back(model(8'h01, 8'h02, 1'b0, t0));
    @(negedge clk);
    da = 8'h10;
    db = 8'h20;
    dc = 1'b1;
    q.push_back(model(8'h10, 8'h20, 1'b1, t0 + (W+1)*P));
    begin
      int k = 0;
      while (!done && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!done) chk("b2b_timeout", 1, 0);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done_drain();
    chk("b2b_sum", sum, 8'h31);

    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom()), W'($urandom()), 1'($urandom()), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_done_drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
